arith_unit_scheduler: RTL and testbench

Round-robin scheduler that shares one flattened-bus arithmetic wrapper (adder_wrapper, multiplier_wrapper or a generated top of them) between NREQ requesters. It grants one request at a time and drives the wrapper's `in_flat` from a holding register. It waits a fixed latency, captures `out_flat`, and returns the result with the requester's ID over a valid/ready response channel. It sits between fuzz-stimulus sources and a single instance of a module under test.

---
 rtl/arith_unit_scheduler.sv | 145 ++++++++++++++
 tb/tb_arith_unit_scheduler.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/arith_unit_scheduler.sv
// Round-robin scheduler that time-shares one flattened-bus arithmetic wrapper between NREQ requesters.
// Optional op counter output is enabled by defining ARITH_SCHED_STATS_EN.
module arith_unit_scheduler #(
  parameter int NREQ  = 4,
  parameter int IN_W  = 4,
  parameter int OUT_W = 5,
  parameter int LAT   = 0,
  parameter int ID_W  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [NREQ*IN_W-1:0] req_data,
  output logic [NREQ-1:0]      req_ready,
  output logic [IN_W-1:0]      unit_in_flat,
  input  logic [OUT_W-1:0]     unit_out_flat,
  output logic                 rsp_valid,
  output logic [ID_W-1:0]      rsp_id,
  output logic [OUT_W-1:0]     rsp_data,
  input  logic                 rsp_ready,
  output logic                 busy
`ifdef ARITH_SCHED_STATS_EN
  ,
  output logic [15:0]          op_count
`endif
);

  typedef enum logic [1:0] {IDLE, DRIVE, CAPTURE, RESP} state_t;

  state_t            state_q, state_d;
  logic [ID_W-1:0]   ptr_q, ptr_d;
  logic [ID_W-1:0]   id_q, id_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [IN_W-1:0]   in_q, in_d;
  logic [OUT_W-1:0]  data_q, data_d;
  logic [ID_W-1:0]   grant_idx;
  logic              grant_found;
  logic [IN_W-1:0]   grant_data;

  // Two passes: first the indices at or above ptr, then wrap to the lowest valid index.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    for (int j = 0; j < NREQ; j++) begin
      if (!grant_found && req_valid[j] && (ID_W'(j) >= ptr_q)) begin
        grant_found = 1'b1;
        grant_idx   = ID_W'(j);
      end
    end
    for (int j = 0; j < NREQ; j++) begin
      if (!grant_found && req_valid[j]) begin
        grant_found = 1'b1;
        grant_idx   = ID_W'(j);
      end
    end
  end

  always_comb begin
    grant_data = '0;
    for (int j = 0; j < NREQ; j++) begin
      if (ID_W'(j) == grant_idx) grant_data = req_data[j*IN_W +: IN_W];
    end
  end

  always_comb begin
    req_ready = '0;
    if ((state_q == IDLE) && !rst && grant_found) req_ready[grant_idx] = 1'b1;
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    id_d    = id_q;
    cnt_d   = cnt_q;
    in_d    = in_q;
    data_d  = data_q;
    case (state_q)
      IDLE: begin
        if (grant_found) begin
          in_d    = grant_data;
          id_d    = grant_idx;
          ptr_d   = (grant_idx == ID_W'(NREQ - 1)) ? '0 : grant_idx + ID_W'(1);
          cnt_d   = 4'(LAT);
          state_d = DRIVE;
        end
      end
      DRIVE: begin
        if (cnt_q == 4'd0) state_d = CAPTURE;
        else               cnt_d   = cnt_q - 4'd1;
      end
      CAPTURE: begin
        data_d  = unit_out_flat;
        state_d = RESP;
      end
      RESP: begin
        if (rsp_ready) begin
          in_d    = '0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      id_q    <= '0;
      cnt_q   <= '0;
      in_q    <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      id_q    <= id_d;
      cnt_q   <= cnt_d;
      in_q    <= in_d;
      data_q  <= data_d;
    end
  end

  assign unit_in_flat = in_q;
  assign rsp_valid    = (state_q == RESP);
  assign rsp_id       = id_q;
  assign rsp_data     = data_q;
  assign busy         = (state_q != IDLE);

`ifdef ARITH_SCHED_STATS_EN
  logic [15:0] op_cnt_q, op_cnt_d;

  always_comb begin
    op_cnt_d = op_cnt_q;
    if ((state_q == RESP) && rsp_ready && (op_cnt_q != 16'hFFFF)) op_cnt_d = op_cnt_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) op_cnt_q <= '0;
    else     op_cnt_q <= op_cnt_d;
  end

  assign op_count = op_cnt_q;
`endif

endmodule

// File: tb/tb_arith_unit_scheduler.sv
// Randomized scoreboard bench for arith_unit_scheduler (NREQ=4, IN_W=4, OUT_W=5, LAT=3).
// The wrapper is modelled as identity with an injected per-cycle XOR disturbance.
module tb_arith_unit_scheduler;
  localparam int NREQ = 4;
  localparam int IN_W = 4;
  localparam int OUT_W = 5;
  localparam int LAT = 3;
  localparam int ID_W = 2;
  localparam int NCYC = 4000;
  localparam int DIRECTED_END = 200;

  logic              clk = 1'b0;
  logic              rst;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ*IN_W-1:0] req_data;
  logic [NREQ-1:0]   req_ready;
  logic [IN_W-1:0]   unit_in_flat;
  logic [OUT_W-1:0]  unit_out_flat;
  logic              rsp_valid;
  logic [ID_W-1:0]   rsp_id;
  logic [OUT_W-1:0]  rsp_data;
  logic              rsp_ready;
  logic              busy;
`ifdef ARITH_SCHED_STATS_EN
  logic [15:0]       op_count;
`endif
  logic [OUT_W-1:0]  noise;

  arith_unit_scheduler #(.NREQ(NREQ), .IN_W(IN_W), .OUT_W(OUT_W), .LAT(LAT)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
    .unit_in_flat(unit_in_flat), .unit_out_flat(unit_out_flat),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data), .rsp_ready(rsp_ready),
    .busy(busy)
`ifdef ARITH_SCHED_STATS_EN
    , .op_count(op_count)
`endif
  );

  assign unit_out_flat = {1'b0, unit_in_flat} ^ noise;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         id;
    logic [3:0] data;
    int         due;
    int         cap;
  } item_t;

  item_t      sb[$];
  logic [4:0] noise_hist [0:NCYC+16];
  int         n_cmp = 0;
  int         n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s cyc=%0d got=%0h expected=%0h", nm, cyc, act, exp);
    end
  endtask

  // Stimulus plus reference model: who is granted, when the unit is busy, what it drives.
  initial begin
    bit         pend [NREQ];
    logic [3:0] rdata [NREQ];
    logic [3:0] exp_rdy;
    logic [3:0] s_data;
    int         ptr, g, c, s_acc, s_due, hold, stats;
    bit         serving, just_rst, directed;
    item_t      it;

    ptr = 0; serving = 0; s_acc = 0; s_due = 0; s_data = '0;
    hold = 0; stats = 0; just_rst = 0;
    for (int i = 0; i < NREQ; i++) begin
      pend[i]  = 1'b1;
      rdata[i] = 4'(i + 1);
    end
    rst = 1'b1; rsp_ready = 1'b1; noise = '0;
    req_valid = 4'hF; req_data = 16'h4321;

    for (int k = 0; k < NCYC; k++) begin
      @(posedge clk); #1;
      directed = (cyc < DIRECTED_END);
      rst = (cyc < 3);
      if (!directed && serving && (cyc >= s_acc + 1) && (cyc <= s_acc + LAT + 1) &&
          ($urandom_range(0, 29) == 0))
        rst = 1'b1;

      for (int i = 0; i < NREQ; i++) begin
        if (!pend[i]) begin
          if (directed || ($urandom_range(0, 99) < 30)) begin
            pend[i]  = 1'b1;
            rdata[i] = directed ? 4'(i + 1) : 4'($urandom);
          end
        end else if (!directed && ($urandom_range(0, 99) < 2)) begin
          pend[i] = 1'b0;
        end
        req_valid[i]             = pend[i];
        req_data[i*IN_W +: IN_W] = rdata[i];
      end

      if (directed) begin
        rsp_ready = 1'b1;
        noise     = '0;
      end else begin
        if (hold > 0) begin
          rsp_ready = 1'b0;
          hold--;
        end else if ($urandom_range(0, 19) == 0) begin
          hold      = 10;
          rsp_ready = 1'b0;
        end else begin
          rsp_ready = ($urandom_range(0, 3) != 0);
        end
        noise = ($urandom_range(0, 9) < 3) ? 5'($urandom) : 5'd0;
      end
      noise_hist[cyc] = noise;

      @(negedge clk);
      g = -1;
      exp_rdy = '0;
      if (!rst && !serving) begin
        for (int j = 0; j < NREQ; j++) begin
          c = (ptr + j) % NREQ;
          if (g < 0 && pend[c]) g = c;
        end
      end
      if (g >= 0) exp_rdy[g] = 1'b1;
      chk("req_ready", 32'(req_ready), 32'(exp_rdy));
      chk("busy", 32'(busy), 32'(serving));
      chk("unit_in_flat", 32'(unit_in_flat), serving ? 32'(s_data) : 32'd0);
`ifdef ARITH_SCHED_STATS_EN
      chk("op_count", 32'(op_count), 32'(stats));
`endif
      if (just_rst) begin
        chk("rsp_id_after_reset", 32'(rsp_id), 32'd0);
        chk("rsp_data_after_reset", 32'(rsp_data), 32'd0);
        just_rst = 1'b0;
      end

      if (rst) begin
        serving  = 1'b0;
        ptr      = 0;
        stats    = 0;
        just_rst = 1'b1;
        sb.delete();
      end else if (g >= 0) begin
        it.id   = g;
        it.data = rdata[g];
        it.cap  = cyc + LAT + 2;
        it.due  = cyc + LAT + 3;
        sb.push_back(it);
        serving = 1'b1;
        s_acc   = cyc;
        s_due   = cyc + LAT + 3;
        s_data  = rdata[g];
        ptr     = (g + 1) % NREQ;
        pend[g] = 1'b0;
      end else if (serving && (cyc >= s_due) && rsp_ready) begin
        serving = 1'b0;
        if (stats < 65535) stats++;
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

  // Response monitor: valid must rise exactly when the oldest op is due and hold its payload.
  initial begin
    bit         exp_v;
    logic [4:0] exp_d;
    forever begin
      @(negedge clk);
      exp_v = (sb.size() > 0) && (cyc >= sb[0].due);
      chk("rsp_valid", 32'(rsp_valid), 32'(exp_v));
      if (exp_v && rsp_valid) begin
        exp_d = {1'b0, sb[0].data} ^ noise_hist[sb[0].cap];
        chk("rsp_id", 32'(rsp_id), 32'(sb[0].id));
        chk("rsp_data", 32'(rsp_data), 32'(exp_d));
        if (rsp_ready) void'(sb.pop_front());
      end
    end
  end

endmodule
